// File: rtl/cp_remove_pkg.sv
// Shared OFDM constants, state encoding and sample helpers for the
// cyclic-prefix remover.
package cp_remove_pkg;

    localparam int N_FFT_P  = 64;
    localparam int CP_LEN_P = 16;
    localparam int CP_TOL_P = 4;
    localparam int SW       = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SKIP = 2'd1,
        PASS = 2'd2
    } state_e;

    // |a - b| in SW+1 bits; the widened difference never overflows.
    function automatic logic [SW:0] abs_diff(
        input logic [SW-1:0] a,
        input logic [SW-1:0] b
    );
        logic signed [SW:0] d;
        logic [SW:0]        r;
        d = $signed({a[SW-1], a}) - $signed({b[SW-1], b});
        r = d[SW] ? -d : d;
        return r;
    endfunction

endpackage

// File: rtl/cp_remove_if.sv
// Sample-stream bundle between the CP remover and its neighbours.
interface cp_remove_if;
    import cp_remove_pkg::*;

    logic                 di_en;
    logic                 di_sof;
    logic signed [SW-1:0] di_re;
    logic signed [SW-1:0] di_im;

    logic                 do_en;
    logic                 do_sos;
    logic                 do_eos;
    logic signed [SW-1:0] do_re;
    logic signed [SW-1:0] do_im;
    logic                 cp_ok;
    logic                 sync_err;

    modport master (
        output di_en, di_sof, di_re, di_im,
        input  do_en, do_sos, do_eos, do_re, do_im, cp_ok, sync_err
    );

    modport slave (
        input  di_en, di_sof, di_re, di_im,
        output do_en, do_sos, do_eos, do_re, do_im, cp_ok, sync_err
    );

endinterface

// File: rtl/cp_buffer.sv
// Prefix store: one write port, one combinational read port.
// Contents are not reset; every slot is rewritten before it is read.
module cp_buffer #(
    parameter int DEPTH = 16,
    parameter int W     = 32,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cp_remove.sv
// Strips the cyclic prefix from each OFDM symbol, forwards the body
// and reports whether the prefix matched the body tail.
module cp_remove
    import cp_remove_pkg::*;
#(
    parameter int N_FFT  = N_FFT_P,
    parameter int CP_LEN = CP_LEN_P,
    parameter int CP_TOL = CP_TOL_P
) (
    input  logic     clk,
    input  logic     reset,
    cp_remove_if.slave bus
);

    localparam int CW = $clog2(N_FFT + CP_LEN);
    localparam int AW = (CP_LEN > 1) ? $clog2(CP_LEN) : 1;
    localparam logic [SW:0] TOL = (SW+1)'(CP_TOL);

    state_e               state_q;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic                 flag_q;
    logic                 do_en_q;
    logic                 do_sos_q;
    logic                 do_eos_q;
    logic                 cp_ok_q;
    logic                 sync_err_q;
    logic signed [SW-1:0] do_re_q;
    logic signed [SW-1:0] do_im_q;

    logic                 sof_err;
    logic                 start;
    logic                 buf_we;
    logic [AW-1:0]        buf_waddr;
    logic [AW-1:0]        buf_raddr;
    logic [2*SW-1:0]      buf_rdata;
    logic                 tail;
    logic                 match;

    // A di_sof is only legal as the first sample of a prefix.
    assign sof_err = bus.di_en && bus.di_sof &&
                     ((state_q == PASS) ||
                      (state_q == SKIP && cnt_q != '0));

    assign start = bus.di_en &&
                   ((state_q == IDLE && bus.di_sof) || sof_err ||
                    (state_q == SKIP && cnt_q == '0));

    assign buf_we    = start || (bus.di_en && state_q == SKIP);
    assign buf_waddr = start ? '0 : cnt_q[AW-1:0];
    assign buf_raddr = AW'(cnt_q - CW'(N_FFT - CP_LEN));
    assign cnt_d     = cnt_q + CW'(1);

    assign tail  = (cnt_q >= CW'(N_FFT - CP_LEN));
    assign match = !tail ||
                   ((abs_diff(bus.di_re, buf_rdata[2*SW-1:SW]) <= TOL) &&
                    (abs_diff(bus.di_im, buf_rdata[SW-1:0]) <= TOL));

    cp_buffer #(
        .DEPTH (CP_LEN),
        .W     (2 * SW),
        .AW    (AW)
    ) u_cp_buffer (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (buf_waddr),
        .wdata_i ({bus.di_re, bus.di_im}),
        .raddr_i (buf_raddr),
        .rdata_o (buf_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            flag_q     <= 1'b1;
            do_en_q    <= 1'b0;
            do_sos_q   <= 1'b0;
            do_eos_q   <= 1'b0;
            cp_ok_q    <= 1'b0;
            sync_err_q <= 1'b0;
            do_re_q    <= '0;
            do_im_q    <= '0;
        end else begin
            do_en_q    <= 1'b0;
            do_sos_q   <= 1'b0;
            do_eos_q   <= 1'b0;
            cp_ok_q    <= 1'b0;
            sync_err_q <= 1'b0;
            if (start) begin
                sync_err_q <= sof_err;
                flag_q     <= 1'b1;
                if (CP_LEN == 1) begin
                    state_q <= PASS;
                    cnt_q   <= '0;
                end else begin
                    state_q <= SKIP;
                    cnt_q   <= CW'(1);
                end
            end else if (bus.di_en) begin
                unique case (state_q)
                    SKIP: begin
                        if (cnt_q == CW'(CP_LEN - 1)) begin
                            state_q <= PASS;
                            cnt_q   <= '0;
                            flag_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    PASS: begin
                        do_en_q  <= 1'b1;
                        do_re_q  <= bus.di_re;
                        do_im_q  <= bus.di_im;
                        do_sos_q <= (cnt_q == '0);
                        flag_q   <= flag_q && match;
                        if (cnt_q == CW'(N_FFT - 1)) begin
                            do_eos_q <= 1'b1;
                            cp_ok_q  <= flag_q && match;
                            state_q  <= SKIP;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.do_en    = do_en_q;
    assign bus.do_sos   = do_sos_q;
    assign bus.do_eos   = do_eos_q;
    assign bus.cp_ok    = cp_ok_q;
    assign bus.sync_err = sync_err_q;
    assign bus.do_re    = do_re_q;
    assign bus.do_im    = do_im_q;

endmodule

// File: tb/tb_cp_remove.sv
// Directed bench for cp_remove: prefix-tolerance table plus
// back-to-back, stall, resync and async-reset sequences.
module tb_cp_remove;
    import cp_remove_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cp_remove_if bus ();

    cp_remove dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    int n_eos  = 0;
    int n_serr = 0;

    typedef struct {
        int          bad;
        logic [15:0] dre;
        logic [15:0] dim;
        bit          ok;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Symbol sample i: prefix carries copies of body samples 64..79.
    function automatic logic [15:0] val(input int i);
        return (i < 16) ? 16'(i + 64) : 16'(i);
    endfunction

    task automatic tick(input logic en, input logic sof,
                        input logic [15:0] re, input logic [15:0] im);
        bus.di_en  = en;
        bus.di_sof = sof;
        bus.di_re  = re;
        bus.di_im  = im;
        @(posedge clk);
        #1;
        if (bus.do_en)    n_out++;
        if (bus.do_eos)   n_eos++;
        if (bus.sync_err) n_serr++;
    endtask

    task automatic stall();
        tick(1'b0, 1'b0, 16'hdead, 16'hbeef);
        chk("stall_quiet", {30'd0, bus.do_en, bus.sync_err}, 32'd0);
    endtask

    task automatic put(input string tag, input logic sof,
                       input logic [15:0] re, input logic [15:0] im,
                       input logic e_en, input logic e_sos,
                       input logic e_eos, input logic e_serr,
                       input logic e_ok);
        tick(1'b1, sof, re, im);
        chk({tag, "_flags"},
            {28'd0, bus.do_en, bus.do_sos, bus.do_eos, bus.sync_err},
            {28'd0, e_en, e_sos, e_eos, e_serr});
        if (e_en)
            chk({tag, "_data"}, {bus.do_re, bus.do_im}, {re, im});
        if (e_eos)
            chk({tag, "_cp_ok"}, {31'd0, bus.cp_ok}, {31'd0, e_ok});
    endtask

    task automatic send_sym(input string tag, input bit sof0,
                            input bit serr0, input int stall_pct,
                            input int bad, input logic [15:0] dre,
                            input logic [15:0] dim, input bit e_ok,
                            input bit out, input int n);
        logic [15:0] re;
        logic [15:0] im;
        for (int i = 0; i < n; i++) begin
            for (int s = 0; s < 3; s++) begin
                if (stall_pct > 0 && $urandom_range(0, 99) < stall_pct)
                    stall();
                else
                    break;
            end
            re = val(i) + ((i == bad) ? dre : 16'd0);
            im = val(i) + ((i == bad) ? dim : 16'd0);
            put(tag, sof0 && i == 0, re, im,
                out && i >= 16, out && i == 16, out && i == 79,
                serr0 && i == 0, e_ok);
        end
    endtask

    vec_t vecs [9];

    initial begin
        vecs[0] = '{70, 16'd5,      16'd0,      1'b0};
        vecs[1] = '{70, 16'd4,      16'd0,      1'b1};
        vecs[2] = '{70, 16'hfffb,   16'd0,      1'b0};
        vecs[3] = '{70, 16'hfffc,   16'd0,      1'b1};
        vecs[4] = '{79, 16'd0,      16'd5,      1'b0};
        vecs[5] = '{64, 16'd0,      16'hfffa,   1'b0};
        vecs[6] = '{63, 16'd100,    16'd100,    1'b1};
        vecs[7] = '{0,  16'd5,      16'd0,      1'b0};
        vecs[8] = '{15, 16'd4,      16'd4,      1'b1};

        reset      = 1'b1;
        bus.di_en  = 1'b0;
        bus.di_sof = 1'b0;
        bus.di_re  = '0;
        bus.di_im  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags",
            {27'd0, bus.do_en, bus.do_sos, bus.do_eos, bus.cp_ok,
             bus.sync_err}, 32'd0);
        chk("reset_data", {bus.do_re, bus.do_im}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Samples without di_sof while idle are discarded.
        send_sym("idle", 1'b0, 1'b0, 0, -1, 0, 0, 1'b0, 1'b0, 20);

        send_sym("one", 1'b1, 1'b0, 0, -1, 0, 0, 1'b1, 1'b1, 80);

        n_out = 0; n_eos = 0; n_serr = 0;
        send_sym("b2b0", 1'b1, 1'b0, 0, -1, 0, 0, 1'b1, 1'b1, 80);
        send_sym("b2b1", 1'b0, 1'b0, 0, -1, 0, 0, 1'b1, 1'b1, 80);
        send_sym("b2b2", 1'b0, 1'b0, 0, -1, 0, 0, 1'b1, 1'b1, 80);
        chk("b2b_outputs", 32'(n_out), 32'd192);
        chk("b2b_eos", 32'(n_eos), 32'd3);
        chk("b2b_sync_err", 32'(n_serr), 32'd0);

        for (int v = 0; v < 9; v++) begin
            send_sym($sformatf("tol%0d", v), 1'b1, 1'b0, 0, vecs[v].bad,
                     vecs[v].dre, vecs[v].dim, vecs[v].ok, 1'b1, 80);
        end

        send_sym("stall", 1'b1, 1'b0, 50, -1, 0, 0, 1'b1, 1'b1, 80);
        stall();

        n_eos = 0; n_serr = 0;
        send_sym("abort", 1'b1, 1'b0, 0, -1, 0, 0, 1'b1, 1'b1, 40);
        send_sym("resync", 1'b1, 1'b1, 0, -1, 0, 0, 1'b1, 1'b1, 80);
        chk("resync_eos", 32'(n_eos), 32'd1);
        chk("resync_sync_err", 32'(n_serr), 32'd1);

        send_sym("prerst", 1'b1, 1'b0, 0, -1, 0, 0, 1'b1, 1'b1, 50);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_flags",
            {27'd0, bus.do_en, bus.do_sos, bus.do_eos, bus.cp_ok,
             bus.sync_err}, 32'd0);
        chk("async_rst_data", {bus.do_re, bus.do_im}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_out = 0; n_eos = 0;
        send_sym("postrst", 1'b0, 1'b0, 0, -1, 0, 0, 1'b0, 1'b0, 80);
        chk("postrst_outputs", 32'(n_out), 32'd0);
        send_sym("recover", 1'b1, 1'b0, 0, -1, 0, 0, 1'b1, 1'b1, 80);
        chk("recover_eos", 32'(n_eos), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp_remove.md
CP_REMOVE -- requirements
Module: cp_remove

Interface
REQ-001 Parameter N_FFT, 64, useful samples per OFDM symbol.
REQ-002 Parameter CP_LEN, 16, cyclic-prefix samples preceding each symbol body; legal range 1..N_FFT.
REQ-003 Parameter CP_TOL, 4, maximum allowed |difference| per rail for the prefix check.
REQ-004 clk  input  1  single system clock; all logic rising-edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 di_en  input  1  input sample valid; low cycles are stalls.
REQ-007 di_sof  input  1  qualified by di_en; marks the first CP sample of a symbol.
REQ-008 di_re / di_im  input  16 each  signed real / imaginary input sample.
REQ-009 do_en  output  1  output sample valid.
REQ-010 do_sos  output  1  high with do_en on body sample 0.
REQ-011 do_re / do_im  output  16 each  signed body sample, passed through unchanged.
REQ-012 do_eos  output  1  high with do_en on body sample N_FFT-1.
REQ-013 cp_ok  output  1  valid only with do_eos; 1 = prefix matched the body tail.
REQ-014 sync_err  output  1  one-cycle pulse on a resynchronising di_sof.

Function
REQ-015 States: IDLE, SKIP, PASS; one sample counter, width ceil(log2(N_FFT+CP_LEN)).
REQ-016 IDLE: di_en=0 or di_sof=0 -> stay in IDLE, samples discarded; di_en=1 and di_sof=1 -> SKIP, counter=1, sample stored to cp_buf[0].
REQ-017 SKIP: each di_en sample is written to cp_buf[counter]; counter increments; the sample at counter=CP_LEN-1 moves to PASS with counter=0.
REQ-018 PASS: each di_en sample is forwarded with counter as body index; index N_FFT-1 -> SKIP-ready state with counter=0, awaiting the next symbol.
REQ-019 After PASS completes, the next di_en sample SHALL be treated as CP sample 0 of the following symbol whether or not di_sof is set, so back-to-back symbols need no gap.
REQ-020 di_sof=1 on a sample that is not expected CP sample 0: pulse sync_err, restart SKIP with this sample as CP sample 0, clear prefix-check state, and emit no do_eos for the aborted symbol.
REQ-021 di_en=0: counter, state, and cp_buf hold; no output is produced; stalls of any length are legal.
REQ-022 Latency: output registered; do_en/do_re/do_im appear exactly 1 clk after the accepted PASS sample; do_en is never high for CP samples.
REQ-023 Prefix check: for body index k >= N_FFT-CP_LEN, compare the sample with cp_buf[k-(N_FFT-CP_LEN)]; compute differences in 17-bit signed and take the absolute value; any rail > CP_TOL clears the per-symbol match flag.
REQ-024 Match flag is set at entry to PASS; cp_ok = flag including the comparison of sample N_FFT-1, driven in the same cycle as do_eos.
REQ-025 No throughput limit: one sample per clk accepted continuously.

Reset
REQ-026 reset asserted: state=IDLE, counter=0, match flag=1; do_en, do_sos, do_eos, cp_ok, sync_err=0; do_re/do_im=0; cp_buf contents don't-care.
REQ-027 Reset mid-symbol aborts the symbol; no partial do_eos is emitted after release; the first post-reset output requires a di_sof.

Structure
REQ-028 Shared OFDM package holds N_FFT=64, CP_LEN=16, sample width 16, and the state encoding.
REQ-029 A single sub-module, cp_buffer (CP_LEN x 32-bit register file, one write port, one read port, combinational read), stores the prefix; all other logic is in cp_remove.

Verification
REQ-030 One symbol, di_sof on sample 0, samples = index 0..79 on re and im, tail equal to CP -> 64 do_en pulses carrying 16..79; do_sos with 16; do_eos with 79; cp_ok=1.
REQ-031 Three back-to-back symbols, di_sof only on the first -> 192 outputs, 3 do_eos pulses, zero sync_err.
REQ-032 Body sample 70 re offset by +5 vs CP sample 6 -> cp_ok=0; offset +4 -> cp_ok=1.
REQ-033 Random di_en stalls (50% duty) on the REQ-030 stimulus -> identical output sequence, each output 1 clk after its input.
REQ-034 di_sof reasserted at input sample 40 -> sync_err pulse, no do_eos for the first symbol, next 80 samples yield a full, correct symbol.
REQ-035 reset asserted asynchronously at input sample 50 -> all outputs 0 immediately; samples without di_sof after release produce no output.
